// File: rtl/iob_pulse_handshake_pkg.sv
// Shared definitions for the pulse-handshake request side: FSM state encoding
// and default parameter values.
package iob_pulse_handshake_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/iob_pulse_handshake_tx_if.sv
// Event/handshake bundle between the source-domain logic and the request side.
// The master modport is the request side; slave is its user and the remote acknowledger.
interface iob_pulse_handshake_tx_if
  import iob_pulse_handshake_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             cke_i;
  logic             pulse_i;
  logic             ack_i;
  logic             req_o;
  logic             busy_o;
  logic [CNT_W-1:0] pending_o;
  logic             done_o;
  logic             ovf_o;

  modport master (
    input  cke_i, pulse_i, ack_i,
    output req_o, busy_o, pending_o, done_o, ovf_o
  );

  modport slave (
    output cke_i, pulse_i, ack_i,
    input  req_o, busy_o, pending_o, done_o, ovf_o
  );

endinterface

// File: rtl/iob_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, with clock enable.
// Reset clears the whole chain, so a stale remote level reappears STAGES edges later.
module iob_sync
  import iob_pulse_handshake_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic cke_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbour; = here would collapse the chain.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      chain_q <= '0;
    end else if (cke_i) begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/iob_pulse_handshake_tx.sv
// Request side of a four-phase pulse-transfer handshake: turns event pulses into
// a held req level, queues events that arrive mid-handshake in a saturating counter.
module iob_pulse_handshake_tx
  import iob_pulse_handshake_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic                      clk_i,
  input logic                      arst_i,
  iob_pulse_handshake_tx_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             ack_s;
  logic             inc, dec, sat;

  iob_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .cke_i (bus.cke_i),
    .d     (bus.ack_i),
    .q     (ack_s)
  );

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    dec     = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A pulse taken straight into REQ is consumed without touching the counter.
        if (!ack_s && (bus.pulse_i || pending_q != '0)) begin
          state_d = REQ;
          dec     = !bus.pulse_i;
        end else begin
          inc = bus.pulse_i;
        end
      end
      REQ: begin
        inc = bus.pulse_i;
        if (ack_s) state_d = RELEASE;
      end
      RELEASE: begin
        inc = bus.pulse_i;
        if (!ack_s) begin
          done_d = 1'b1;
          if (pending_q != '0) begin
            state_d = REQ;
            dec     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    sat       = (pending_q == CNT_MAX);
    ovf_d     = inc && !dec && sat;
    pending_d = pending_q;
    if (inc && !dec && !sat) begin
      pending_d = pending_q + 1'b1;
    end else if (dec && !inc) begin
      pending_d = pending_q - 1'b1;
    end

    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (bus.cke_i) begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.req_o     = req_q;
  assign bus.busy_o    = busy_q;
  assign bus.pending_o = pending_q;
  assign bus.done_o    = done_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_iob_pulse_handshake_tx.sv
// Bench for iob_pulse_handshake_tx: a CNT_W=4 instance for the main scenarios and
// a CNT_W=2 instance for saturation; done/ovf pulses are checked by a scoreboard.
module tb_iob_pulse_handshake_tx;

  localparam int SYNC = 2;

  typedef struct {
    logic [3:0] pending;
    logic       req;
  } exp_t;

  logic clk;
  logic arst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   auto_a   = 0;
  bit   auto_b   = 0;
  int   cnt_a    = 0;
  int   cnt_b    = 0;

  exp_t done_q_a[$];
  exp_t done_q_b[$];
  exp_t ovf_q_a[$];
  exp_t ovf_q_b[$];

  iob_pulse_handshake_tx_if #(.CNT_W(4)) a_if ();
  iob_pulse_handshake_tx_if #(.CNT_W(2)) b_if ();

  iob_pulse_handshake_tx #(.SYNC_STAGES(SYNC), .CNT_W(4)) dut_a (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (a_if)
  );

  iob_pulse_handshake_tx #(.SYNC_STAGES(SYNC), .CNT_W(2)) dut_b (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic req, input logic busy, input int pend);
    check({tag, ".req"},     32'(a_if.req_o),     32'(req));
    check({tag, ".busy"},    32'(a_if.busy_o),    32'(busy));
    check({tag, ".pending"}, 32'(a_if.pending_o), 32'(pend));
  endtask

  task automatic push_done(input bit sel, input logic [3:0] pend, input logic req);
    exp_t e;
    e.pending = pend;
    e.req     = req;
    if (sel) done_q_b.push_back(e);
    else     done_q_a.push_back(e);
  endtask

  task automatic pulse_n(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) b_if.pulse_i = 1'b1;
      else     a_if.pulse_i = 1'b1;
      @(negedge clk);
    end
    a_if.pulse_i = 1'b0;
    b_if.pulse_i = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input string tag, input bit pend_zero);
    int  n;
    bit  busy;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (pend_zero) check({tag, ".pending_zero"}, 32'(a_if.pending_o), 32'd0);
      busy = sel ? b_if.busy_o : a_if.busy_o;
    end while (busy && n < 300);
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout: still busy after %0d cycles, expected idle", tag, n);
    end
    repeat (2) @(negedge clk);
  endtask

  // Remote acknowledger: follows req with a 3-cycle delay in each direction.
  always @(negedge clk) begin
    if (auto_a) begin
      if (a_if.req_o != a_if.ack_i) begin
        cnt_a++;
        if (cnt_a >= 3) begin
          a_if.ack_i = a_if.req_o;
          cnt_a      = 0;
        end
      end else begin
        cnt_a = 0;
      end
    end
    if (auto_b) begin
      if (b_if.req_o != b_if.ack_i) begin
        cnt_b++;
        if (cnt_b >= 3) begin
          b_if.ack_i = b_if.req_o;
          cnt_b      = 0;
        end
      end else begin
        cnt_b = 0;
      end
    end
  end

  // Scoreboard monitor: every done/ovf pulse must match the next queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (a_if.done_o) begin
      if (done_q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_a.unexpected: got done_o=1, expected no done pulse");
      end else begin
        e = done_q_a.pop_front();
        check("done_a.pending", 32'(a_if.pending_o), 32'(e.pending));
        check("done_a.req",     32'(a_if.req_o),     32'(e.req));
      end
    end
    if (a_if.ovf_o) begin
      if (ovf_q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ovf_a.unexpected: got ovf_o=1, expected no overflow");
      end else begin
        e = ovf_q_a.pop_front();
        check("ovf_a.pending", 32'(a_if.pending_o), 32'(e.pending));
      end
    end
    if (b_if.done_o) begin
      if (done_q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_b.unexpected: got done_o=1, expected no done pulse");
      end else begin
        e = done_q_b.pop_front();
        check("done_b.pending", 32'(b_if.pending_o), 32'(e.pending));
        check("done_b.req",     32'(b_if.req_o),     32'(e.req));
      end
    end
    if (b_if.ovf_o) begin
      if (ovf_q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ovf_b.unexpected: got ovf_o=1, expected no overflow");
      end else begin
        e = ovf_q_b.pop_front();
        check("ovf_b.pending", 32'(b_if.pending_o), 32'(e.pending));
        check("ovf_b.req",     32'(b_if.req_o),     32'(e.req));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;

    arst         = 1'b1;
    a_if.cke_i   = 1'b1;
    a_if.pulse_i = 1'b0;
    a_if.ack_i   = 1'b0;
    b_if.cke_i   = 1'b1;
    b_if.pulse_i = 1'b0;
    b_if.ack_i   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk_a("reset_a", 1'b0, 1'b0, 0);
    check("reset_a.done", 32'(a_if.done_o), 32'd0);
    check("reset_a.ovf",  32'(a_if.ovf_o),  32'd0);
    check("reset_b.req",     32'(b_if.req_o),     32'd0);
    check("reset_b.pending", 32'(b_if.pending_o), 32'd0);
    arst = 1'b0;
    @(negedge clk);
    chk_a("post_reset_a", 1'b0, 1'b0, 0);

    // Single event
    auto_a = 1;
    push_done(0, 4'd0, 1'b0);
    pulse_n(0, 1);
    chk_a("single.after_pulse", 1'b1, 1'b1, 0);
    wait_idle(0, "single", 1'b1);
    check("single.done_count", 32'(done_q_a.size()), 32'd0);
    chk_a("single.end", 1'b0, 1'b0, 0);

    // Burst of 5: one direct, four queued, each done re-enters REQ on the same edge
    push_done(0, 4'd3, 1'b1);
    push_done(0, 4'd2, 1'b1);
    push_done(0, 4'd1, 1'b1);
    push_done(0, 4'd0, 1'b1);
    push_done(0, 4'd0, 1'b0);
    pulse_n(0, 5);
    chk_a("burst.queued", 1'b1, 1'b1, 4);
    wait_idle(0, "burst", 1'b0);
    check("burst.done_count", 32'(done_q_a.size()), 32'd0);
    chk_a("burst.end", 1'b0, 1'b0, 0);

    // Saturation on the CNT_W=2 instance with ack held low
    e.pending = 4'd3;
    e.req     = 1'b1;
    ovf_q_b.push_back(e);
    ovf_q_b.push_back(e);
    pulse_n(1, 6);
    check("sat.pending", 32'(b_if.pending_o), 32'd3);
    check("sat.req",     32'(b_if.req_o),     32'd1);
    @(negedge clk);
    check("sat.ovf_cleared", 32'(b_if.ovf_o), 32'd0);
    check("sat.ovf_count",   32'(ovf_q_b.size()), 32'd0);
    push_done(1, 4'd2, 1'b1);
    push_done(1, 4'd1, 1'b1);
    push_done(1, 4'd0, 1'b1);
    push_done(1, 4'd0, 1'b0);
    auto_b = 1;
    wait_idle(1, "sat", 1'b0);
    check("sat.done_count", 32'(done_q_b.size()), 32'd0);
    check("sat.end_busy",   32'(b_if.busy_o),     32'd0);

    // Simultaneous increment and decrement on RELEASE completion
    auto_a = 0;
    push_done(0, 4'd2, 1'b1);
    push_done(0, 4'd1, 1'b1);
    push_done(0, 4'd0, 1'b1);
    push_done(0, 4'd0, 1'b0);
    pulse_n(0, 3);
    chk_a("simul.queued", 1'b1, 1'b1, 2);
    a_if.ack_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_if.req_o && n < 20);
    chk_a("simul.release", 1'b0, 1'b1, 2);
    a_if.ack_i = 1'b0;
    repeat (SYNC) @(negedge clk);
    a_if.pulse_i = 1'b1;
    @(negedge clk);
    a_if.pulse_i = 1'b0;
    chk_a("simul.reenter", 1'b1, 1'b1, 2);
    check("simul.ovf", 32'(a_if.ovf_o), 32'd0);
    auto_a = 1;
    wait_idle(0, "simul", 1'b0);
    check("simul.done_count", 32'(done_q_a.size()), 32'd0);

    // Stale ack held through reset
    auto_a     = 0;
    a_if.ack_i = 1'b1;
    arst       = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    chk_a("stale.reset", 1'b0, 1'b0, 0);
    repeat (SYNC + 1) @(negedge clk);
    push_done(0, 4'd0, 1'b0);
    pulse_n(0, 1);
    chk_a("stale.counted", 1'b0, 1'b0, 1);
    a_if.ack_i = 1'b0;
    for (int i = 0; i < SYNC; i++) begin
      @(negedge clk);
      chk_a("stale.wait", 1'b0, 1'b0, 1);
    end
    @(negedge clk);
    chk_a("stale.req", 1'b1, 1'b1, 0);
    auto_a = 1;
    wait_idle(0, "stale", 1'b0);
    check("stale.done_count", 32'(done_q_a.size()), 32'd0);

    // Clock enable freeze during REQ, then asynchronous reset mid-handshake
    auto_a = 0;
    pulse_n(0, 2);
    chk_a("cke.before", 1'b1, 1'b1, 1);
    a_if.cke_i   = 1'b0;
    a_if.pulse_i = 1'b1;
    a_if.ack_i   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_a("cke.frozen", 1'b1, 1'b1, 1);
    end
    a_if.cke_i   = 1'b1;
    a_if.pulse_i = 1'b0;
    a_if.ack_i   = 1'b0;
    @(negedge clk);
    chk_a("cke.resumed", 1'b1, 1'b1, 1);
    #2;
    arst = 1'b1;
    #1;
    chk_a("midrst", 1'b0, 1'b0, 0);
    check("midrst.done", 32'(a_if.done_o), 32'd0);
    check("midrst.ovf",  32'(a_if.ovf_o),  32'd0);
    @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    chk_a("midrst.after", 1'b0, 1'b0, 0);

    check("final.done_q_a", 32'(done_q_a.size()), 32'd0);
    check("final.ovf_q_a",  32'(ovf_q_a.size()),  32'd0);
    check("final.done_q_b", 32'(done_q_b.size()), 32'd0);
    check("final.ovf_q_b",  32'(ovf_q_b.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_pulse_handshake_tx.md
# iob_pulse_handshake_tx

Request side of a four-phase (req/ack) pulse-transfer handshake, in the source clock domain. Single-cycle event pulses become a request level on `req_o` that is held until the remote domain's acknowledge comes back through an internal synchronizer. Events arriving during a handshake are queued in a saturating pending counter, so bursts are not lost up to the counter limit. Pairs with a slow-domain acknowledger that synchronizes `req_o` and returns `ack_i`.

## Interface
- `SYNC_STAGES`, 2 — flops in the `ack_i` synchronizer chain; legal values are 2 or more.
- `CNT_W`, 4 — pending-counter width; maximum pending count is 2^CNT_W−1.

- `clk_i` input 1 — source-domain clock.
- `arst_i` input 1 — reset, asynchronous, active-high.
- `cke_i` input 1 — clock enable; when low, every register holds.
- `pulse_i` input 1 — event strobe; each cycle high with `cke_i`=1 is one event.
- `ack_i` input 1 — asynchronous acknowledge from the remote domain.
- `req_o` output 1 — registered request level to the remote domain.
- `busy_o` output 1 — registered; high when the FSM is not in IDLE.
- `pending_o` output CNT_W — queued events not yet requested.
- `done_o` output 1 — one-cycle pulse on handshake completion.
- `ovf_o` output 1 — one-cycle pulse when an event is dropped because the counter is saturated.

## Operation
- `ack_s` is `ack_i` after SYNC_STAGES flops clocked by `clk_i`.
- The FSM has three states. `req_o` = (state==REQ). `busy_o` = (state!=IDLE).
- **IDLE**
  - If `ack_s`=0 and (`pulse_i` or `pending_o`>0), go to REQ.
  - A pending event is consumed (counter −1) only when `pulse_i`=0.
  - If `ack_s`=1 (stale ack after a reset), stay in IDLE. Any `pulse_i` is counted as pending.
- **REQ**
  - Hold `req_o`=1.
  - On `ack_s`=1, go to RELEASE.
- **RELEASE**
  - Hold `req_o`=0.
  - On `ack_s`=0:
    - pulse `done_o`;
    - if `pending_o`>0, go to REQ and decrement the counter;
    - otherwise go to IDLE.
- **Pending counter**
  - +1 on any `pulse_i` not consumed directly by an IDLE→REQ transition.
  - −1 on each REQ entry that serves a queued event.
  - Simultaneous +1 and −1: the value is unchanged.
  - At 2^CNT_W−1, an increment without a simultaneous decrement is dropped, and `ovf_o` pulses.
- **cke_i=0**: the FSM, counter, synchronizer and outputs all freeze. `pulse_i` is ignored. `done_o` and `ovf_o` are forced low on the next enabled edge only if their condition no longer holds.

## Timing
- Reset values: `req_o`=0, `busy_o`=0, `pending_o`=0, `done_o`=0, `ovf_o`=0, synchronizer=0, state=IDLE.
- Reset mid-handshake drops `req_o` immediately. Queued events are lost.
- All outputs are registered.
- `pulse_i` at edge t in IDLE: `req_o`=1 and `busy_o`=1 after edge t.
- `ack_i` rise: `ack_s`=1 after SYNC_STAGES edges. `req_o` falls one edge later.
- `ack_i` fall: `ack_s`=0 after SYNC_STAGES edges. On the next edge `done_o`=1 for one cycle and the FSM leaves RELEASE.
- Back-to-back queued events: `req_o` rises on the same edge that `done_o` rises.
- Minimum handshake with an instant remote ack: 2·SYNC_STAGES+2 cycles.

## Structure
- Shared package `iob_pulse_handshake_pkg` holds:
  - state encoding constants `IDLE`=2'd0, `REQ`=2'd1, `RELEASE`=2'd2;
  - the default parameter constants.
- One sub-module: `iob_sync`, a parameterized SYNC_STAGES-deep flop chain with async reset and `cke_i`, used for `ack_i`.

## Test plan
- **Single event.** Reset; pulse `pulse_i` for 1 cycle; remote model acks 3 cycles after `req_o` and releases 3 cycles after `req_o` falls. Expect `req_o` high → low, exactly one `done_o`, `pending_o`=0 throughout, `busy_o` low at the end.
- **Burst.** 5 consecutive `pulse_i` cycles in IDLE. Expect `pending_o`=4 and exactly 5 `done_o` pulses. `pending_o` steps 4→0 at each REQ re-entry.
- **Saturation.** CNT_W=2; 6 pulses while stalled in REQ (ack held low). Expect `pending_o`=3 and `ovf_o` pulsing on pulses 5 and 6 (the first pulse goes direct; pulses 2–4 are queued). After ack cycles, 4 `done_o` pulses.
- **Simultaneous.** `pulse_i` on the same edge RELEASE completes with `pending_o`=2. Expect `pending_o` to stay 2, `req_o` to rise, and no `ovf_o`.
- **Stale ack.** Hold `ack_i`=1 through reset, then pulse `pulse_i`. Expect `req_o`=0 and `pending_o`=1. Drop `ack_i`; `req_o` rises SYNC_STAGES+1 cycles later and `pending_o` goes to 0.
- **Clock enable and mid-handshake reset.** With `cke_i`=0 for 10 cycles during REQ, all outputs and the counter hold and pulses are ignored. Asserting `arst_i` mid-REQ drives every output to 0 asynchronously.
